// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm
// Description : Miss/fill and LRU-refresh controller for a 2-way set-associative
//               cache. Picks the victim from the LRU array, fetches the block
//               word by word, writes data and tag arrays, then updates LRU.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_fsm #(
    parameter int SETS        = 64,
    parameter int WORDS       = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hit,
    input  logic                       hit_way,
    input  logic                       miss,
    input  logic [$clog2(SETS)-1:0]    set_index,
    input  logic [15:0]                miss_addr,
    input  logic                       block0_isLRU,
    input  logic                       mem_data_valid,
    input  logic [15:0]                mem_data,
    output logic                       stall,
    output logic                       mem_en,
    output logic [15:0]                mem_addr,
    output logic                       data_we,
    output logic                       data_way,
    output logic [$clog2(WORDS)-1:0]   data_word,
    output logic [15:0]                data_wdata,
    output logic                       tag_we,
    output logic                       lru_we,
    output logic [SETS-1:0]            lru_set_en,
    output logic                       lru_block,
    output logic                       fill_done
);

    localparam int c_set_w = $clog2(SETS);
    localparam int c_cnt_w = $clog2(WORDS);
    localparam int c_off_w = c_cnt_w + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DRAIN  = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_set_w-1:0]     r_set;
    logic [15-c_off_w:0]    r_block;
    logic                   r_victim;
    logic [c_cnt_w-1:0]     r_issue_cnt;
    logic [c_cnt_w-1:0]     r_recv_cnt;

    logic w_idle;
    logic w_update;
    logic w_hit_upd;
    logic w_recv;

    assign w_idle    = (r_state == S_IDLE);
    assign w_update  = !rst && (r_state == S_UPDATE);
    assign w_hit_upd = !rst && w_idle && hit && !miss;
    assign w_recv    = !rst && !w_idle && mem_data_valid;

    always_comb begin
        stall      = !rst && (!w_idle || miss);
        mem_en     = !rst && (r_state == S_FETCH);
        mem_addr   = '0;
        data_we    = 1'b0;
        data_way   = 1'b0;
        data_word  = '0;
        data_wdata = '0;
        tag_we     = 1'b0;
        lru_we     = 1'b0;
        lru_set_en = '0;
        lru_block  = 1'b0;
        fill_done  = 1'b0;

        // Word offset comes straight from the counter, so the address never
        // carries out of the block.
        if (mem_en) begin
            mem_addr = {r_block, r_issue_cnt, 1'b0};
        end
        if (w_recv) begin
            data_we    = 1'b1;
            data_way   = r_victim;
            data_word  = r_recv_cnt;
            data_wdata = mem_data;
        end
        if (w_update) begin
            tag_we     = 1'b1;
            data_way   = r_victim;
            fill_done  = 1'b1;
            lru_we     = 1'b1;
            lru_set_en = SETS'(1) << r_set;
            lru_block  = ~r_victim;
        end else if (w_hit_upd) begin
            lru_we     = 1'b1;
            lru_set_en = SETS'(1) << set_index;
            lru_block  = ~hit_way;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_set       <= '0;
            r_block     <= '0;
            r_victim    <= 1'b0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (miss) begin
                        r_state     <= S_FETCH;
                        r_set       <= set_index;
                        r_block     <= miss_addr[15:c_off_w];
                        r_victim    <= ~block0_isLRU;
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_issue_cnt == c_last) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_issue_cnt <= r_issue_cnt + c_cnt_w'(1);
                    end
                end
                S_DRAIN:  r_state <= S_DRAIN;
                S_UPDATE: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase

            // Last returned word overrides the FETCH->DRAIN move (zero-latency memory).
            if (w_recv && r_state != S_UPDATE) begin
                if (r_recv_cnt == c_last) begin
                    r_state <= S_UPDATE;
                end else begin
                    r_recv_cnt <= r_recv_cnt + c_cnt_w'(1);
                end
            end
        end
    end

    // A return can never overtake the request it answers.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_FETCH && mem_data_valid) begin
            assert (MEM_LATENCY == 0 ? (r_recv_cnt <= r_issue_cnt) : (r_recv_cnt < r_issue_cnt));
        end
    end

endmodule
`default_nettype wire
